// File: rtl/decoder_scan.sv
// decoder_scan: registered one-hot decoder with a direct-select mode and an
// auto-scan mode that walks the index with a programmable dwell time.
//
// Ports
//   clk    in   1      sole clock, rising edge
//   rst    in   1      asynchronous active-high reset
//   en     in   1      block enable (0 forces OFF, has precedence over mode)
//   mode   in   1      0 = direct decode of code, 1 = auto-scan
//   code   in   N      select value in direct mode
//   dwell  in   DW     scan hold time in cycles minus one
//   out    out  2**N   registered one-hot of idx (all zero while OFF)
//   idx    out  N      registered index currently decoded
//   wrap   out  1      one-cycle pulse when scan wraps 2**N-1 -> 0
module decoder_scan #(
  parameter int N  = 3,
  parameter int DW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            mode,
  input  logic [N-1:0]    code,
  input  logic [DW-1:0]   dwell,
  output logic [2**N-1:0] out,
  output logic [N-1:0]    idx,
  output logic            wrap
);
  localparam int W = 2**N;

  typedef enum logic [1:0] {OFF, DIRECT, SCAN} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    idx_q, idx_d;
  logic [W-1:0]    out_q, out_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic            wrap_q, wrap_d;

  // The registered outputs at each edge follow the state being entered, so
  // a mode/enable change takes effect on the same edge that samples it.
  always_comb begin
    state_d = OFF;
    if (en) state_d = mode ? SCAN : DIRECT;

    idx_d  = idx_q;
    cnt_d  = '0;
    wrap_d = 1'b0;
    out_d  = '0;

    case (state_d)
      DIRECT: idx_d = code;
      SCAN: begin
        // Entering SCAN keeps idx with a cleared counter, so the first
        // hold is a full dwell+1 cycles. Dwell is compared live, so a
        // lowered dwell below the running count advances immediately.
        if (state_q == SCAN) begin
          if (cnt_q >= dwell) begin
            idx_d  = idx_q + N'(1);
            wrap_d = (idx_q == {N{1'b1}});
          end else begin
            cnt_d = cnt_q + DW'(1);
          end
        end
      end
      default: ;
    endcase

    if (state_d != OFF) out_d[idx_d] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OFF;
      idx_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
    end
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
module tb_decoder_scan;
  logic       clk = 1'b0;
  logic       rst, en, mode;
  logic [2:0] code;
  logic [3:0] dwell;
  logic [7:0] out;
  logic [2:0] idx;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  decoder_scan #(.N(3), .DW(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .code(code),
    .dwell(dwell), .out(out), .idx(idx), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // advance one rising edge, then settle 1 time unit for sampling/driving
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] o_exp,
                     input logic [2:0] i_exp, input logic w_exp);
    checks++;
    if (out !== o_exp || idx !== i_exp || wrap !== w_exp) begin
      errors++;
      $display("FAIL %s: got out=%h idx=%0d wrap=%b, expected out=%h idx=%0d wrap=%b",
               name, out, idx, wrap, o_exp, i_exp, w_exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 1'b0; code = '0; dwell = '0;
    step(); step();
    chk("reset", 8'h00, 3'd0, 1'b0);
    rst = 1'b0;
    step();
    chk("off_after_reset", 8'h00, 3'd0, 1'b0);
  endtask

  task automatic test_direct();
    logic [7:0] oh;
    en = 1'b1; mode = 1'b0;
    for (int c = 0; c < 8; c++) begin
      code = 3'(c);
      // out must not yet reflect code before the edge
      if (c > 0) begin
        oh = 8'h01 << (c - 1);
        chk("direct_latency", oh, 3'(c - 1), 1'b0);
      end
      step();
      oh = 8'h01 << c;
      chk("direct_sweep", oh, 3'(c), 1'b0);
    end
    code = 3'd0;  // 7 -> 0 in direct must not pulse wrap
    step();
    chk("direct_no_wrap", 8'h01, 3'd0, 1'b0);
  endtask

  task automatic test_scan_dwell0();
    logic [7:0] oh;
    en = 1'b1; mode = 1'b0; code = 3'd0; step();
    mode = 1'b1; dwell = 4'd0;
    step();
    chk("scan0_entry", 8'h01, 3'd0, 1'b0);
    for (int k = 1; k < 8; k++) begin
      step();
      oh = 8'h01 << k;
      chk("scan0_walk", oh, 3'(k), 1'b0);
    end
    step();
    chk("scan0_wrap", 8'h01, 3'd0, 1'b1);
    step();
    chk("scan0_wrap_end", 8'h02, 3'd1, 1'b0);
  endtask

  task automatic test_scan_dwell2();
    int nwrap = 0;
    logic [2:0] ei;
    logic [7:0] oh;
    en = 1'b1; mode = 1'b0; code = 3'd0; step();
    mode = 1'b1; dwell = 4'd2;
    step();
    chk("scan2_entry", 8'h01, 3'd0, 1'b0);
    for (int k = 1; k <= 48; k++) begin
      step();
      ei = 3'((k / 3) % 8);
      oh = 8'h01 << ei;
      if (wrap) nwrap++;
      chk("scan2_hold", oh, ei, (k % 24) == 0);
    end
    checks++;
    if (nwrap !== 2) begin
      errors++;
      $display("FAIL scan2_wrap_count: got %0d, expected 2", nwrap);
    end
  endtask

  task automatic test_dwell_drop();
    en = 1'b1; mode = 1'b0; code = 3'd2; step();
    mode = 1'b1; dwell = 4'd9;
    step();                       // entry, counter 0
    for (int k = 0; k < 6; k++) step();  // counter now 6
    chk("drop_before", 8'h04, 3'd2, 1'b0);
    dwell = 4'd3;
    step();
    chk("drop_advance", 8'h08, 3'd3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("drop_hold", 8'h08, 3'd3, 1'b0);
    end
    step();
    chk("drop_next", 8'h10, 3'd4, 1'b0);
  endtask

  task automatic test_en_mode();
    en = 1'b1; mode = 1'b0; code = 3'd5; step();
    mode = 1'b1; dwell = 4'd2;
    step();
    chk("enm_scan5", 8'h20, 3'd5, 1'b0);
    en = 1'b0;
    step();
    chk("enm_off", 8'h00, 3'd5, 1'b0);
    mode = 1'b0; code = 3'd3;     // en=0 wins over mode
    step();
    chk("enm_precedence", 8'h00, 3'd5, 1'b0);
    en = 1'b1; mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("enm_rescan_hold", 8'h20, 3'd5, 1'b0);
    end
    step();
    chk("enm_rescan_next", 8'h40, 3'd6, 1'b0);
    mode = 1'b0; code = 3'd4;     // SCAN -> DIRECT
    step();
    chk("enm_to_direct", 8'h10, 3'd4, 1'b0);
    mode = 1'b1; dwell = 4'd1;    // counter must restart from 0
    step();
    chk("enm_reentry", 8'h10, 3'd4, 1'b0);
    step();
    chk("enm_reentry_hold", 8'h10, 3'd4, 1'b0);
    step();
    chk("enm_reentry_next", 8'h20, 3'd5, 1'b0);
  endtask

  task automatic test_async_reset();
    en = 1'b1; mode = 1'b0; code = 3'd6; step();
    mode = 1'b1; dwell = 4'd3;
    step();
    chk("arst_pre", 8'h40, 3'd6, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_immediate", 8'h00, 3'd0, 1'b0);
    #1 rst = 1'b0;
    step();
    chk("arst_resume", 8'h01, 3'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan_dwell0();
    test_scan_dwell2();
    test_dwell_drop();
    test_en_mode();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 SHALL have parameter N, default 3, meaning select width; output width is 2**N.
REQ-002 SHALL have parameter DW, default 4, meaning dwell counter width.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  block enable.
REQ-006 SHALL have port mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-007 SHALL have port code  input  N  select value used in direct mode.
REQ-008 SHALL have port dwell  input  DW  scan hold time, in cycles minus one.
REQ-009 SHALL have port out  output  2**N  registered one-hot decode; bit k high selects index k.
REQ-010 SHALL have port idx  output  N  registered index currently decoded.
REQ-011 SHALL have port wrap  output  1  one-cycle pulse when the scan index wraps from 2**N-1 to 0.

Function
REQ-012 SHALL implement FSM states OFF, DIRECT and SCAN, evaluated at every rising clk edge.
REQ-013 SHALL move to OFF when en=0, to DIRECT when en=1 and mode=0, and to SCAN when en=1 and mode=1.
REQ-014 In OFF, SHALL drive out=0 from the next edge, hold idx, clear the dwell counter and keep wrap=0.
REQ-015 In DIRECT, SHALL register idx<=code and out<=one-hot(code), giving latency of exactly 1 cycle from code to out.
REQ-016 In DIRECT, SHALL never assert wrap, even when code moves from 2**N-1 to 0.
REQ-017 In SCAN, SHALL increment the internal DW-bit dwell counter each cycle.
REQ-018 In SCAN, when the counter is >= dwell, SHALL reset the counter to 0 and advance idx by 1 modulo 2**N.
REQ-019 SHALL keep out = one-hot(idx) at all times outside OFF; out SHALL never have more than one bit set.
REQ-020 With dwell=0, SHALL advance idx every cycle in SCAN.
REQ-021 With dwell=D, SHALL hold each index for exactly D+1 cycles in steady state.
REQ-022 SHALL assert wrap for one cycle, registered, coincident with idx becoming 0 after 2**N-1 in SCAN; wrap SHALL be 0 at all other times.
REQ-023 On entry to SCAN from DIRECT or OFF, SHALL start from the current idx with the counter at 0, so the first hold is D+1 cycles.
REQ-024 On SCAN->DIRECT, SHALL take idx/out from code on the next edge and clear the counter.
REQ-025 SHALL treat a dwell change mid-hold immediately; a counter already >= the new dwell SHALL advance idx on the next edge.
REQ-026 With en and mode changing on the same edge, SHALL apply the precedence en=0 -> OFF first.
REQ-027 SHALL support any N from 1 to 6 and any DW from 1 to 16 without code change.

Reset
REQ-028 On rst=1, SHALL asynchronously force state=OFF, out=0, idx=0, wrap=0 and counter=0, regardless of clk.
REQ-029 After rst falls, SHALL resume at the first rising edge per REQ-013; a reset asserted mid-scan SHALL discard the scan position.

Verification (N=3, DW=4)
REQ-030 Direct sweep: en=1, mode=0, code=0..7 one per cycle -> out=0x01,0x02,...,0x80, each one cycle after code, wrap always 0.
REQ-031 Scan dwell=0: en=1, mode=1 from idx=0 -> idx 1,2,...,7,0 on consecutive cycles, out one-hot, wrap high only in the cycle idx=0 appears.
REQ-032 Scan dwell=2: each idx held exactly 3 cycles, full cycle 24 cycles, exactly one wrap pulse per 24 cycles.
REQ-033 Mid-hold dwell drop: dwell=9, counter at 6, dwell set to 3 -> idx advances on the next edge, then holds 4 cycles.
REQ-034 Enable/mode: at idx=5 in SCAN, en=0 -> out=0x00 next cycle with idx held at 5; en=1, mode=1 -> out=0x20 held for dwell+1 cycles, then 0x40.
REQ-035 Async reset: rst pulsed between clk edges during SCAN with idx=6 -> out=0, idx=0, wrap=0 immediately, before the next edge.
